// File: rtl/shift_add_mult_pkg.sv
// Shared types and sizing helpers for the shift-add multiplier.
// Step count and step-counter width are derived from WIDTH and BPC.
package shift_add_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int step_count(input int width, input int bpc);
        return width / bpc;
    endfunction

    function automatic int step_cnt_w(input int width, input int bpc);
        return $clog2(width / bpc) + 1;
    endfunction

endpackage

// File: rtl/mult_step_unit.sv
// Combinational multiply step: BPC-bit digit times multiplicand, accumulated
// at bit offset step*BPC into the 2*WIDTH accumulator.
module mult_step_unit
    import shift_add_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic [WIDTH-1:0]                    mcand_i,
    input  logic [BPC-1:0]                      digit_i,
    input  logic [step_cnt_w(WIDTH, BPC)-1:0]   step_i,
    input  logic [2*WIDTH-1:0]                  acc_i,
    output logic [2*WIDTH-1:0]                  acc_o
);

    logic [2*WIDTH-1:0] pp;

    always_comb begin
        pp    = (2*WIDTH)'(mcand_i) * (2*WIDTH)'(digit_i);
        acc_o = acc_i + (pp << (int'(step_i) * BPC));
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier, WIDTH-bit operands, BPC bits per cycle, signed/unsigned.
// Optional SHIFT_ADD_MULT_EARLY_TERM_EN: leave CALC once the remaining multiplier bits are zero.
module shift_add_multiplier
    import shift_add_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 rdy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   ab
);

    localparam int N  = step_count(WIDTH, BPC);
    localparam int SW = step_cnt_w(WIDTH, BPC);

    state_e             state_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] ab_q;
    logic [SW-1:0]      step_q;
    logic               neg_q;
    logic               rdy_q;
    logic               done_q;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   mplier_d;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] result;
    logic               calc_last;

    mult_step_unit #(
        .WIDTH (WIDTH),
        .BPC   (BPC)
    ) u_step (
        .mcand_i (mcand_q),
        .digit_i (mplier_q[BPC-1:0]),
        .step_i  (step_q),
        .acc_i   (acc_q),
        .acc_o   (acc_d)
    );

    // Most-negative operand maps to 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        a_mag = a;
        b_mag = b;
        if (sgn && a[WIDTH-1]) a_mag = -a;
        if (sgn && b[WIDTH-1]) b_mag = -b;
        mplier_d = mplier_q >> BPC;
        result   = neg_q ? -acc_d : acc_d;
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
        calc_last = (step_q == SW'(N - 1)) || (mplier_d == '0);
`else
        calc_last = (step_q == SW'(N - 1));
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            ab_q     <= '0;
            step_q   <= '0;
            neg_q    <= 1'b0;
            rdy_q    <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (req) begin
                        mcand_q  <= a_mag;
                        mplier_q <= b_mag;
                        neg_q    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc_q    <= '0;
                        step_q   <= '0;
                        rdy_q    <= 1'b0;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_d;
                    step_q   <= step_q + 1'b1;
                    if (calc_last) begin
                        ab_q    <= result;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    rdy_q   <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    rdy_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rdy  = rdy_q;
    assign done = done_q;
    assign ab   = ab_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: an 8-bit/1-bit-per-cycle instance and an
// 8-bit/4-bit-per-cycle instance, table-driven vectors plus busy and reset sequences.
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req1 = 1'b0;
    logic        req4 = 1'b0;
    logic        sgn = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        rdy1, done1, rdy4, done4;
    logic [15:0] ab1, ab4;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    shift_add_multiplier #(.WIDTH(8), .BPC(1)) u_dut1 (
        .clk (clk), .rst_n (rst_n), .req (req1), .sgn (sgn), .a (a), .b (b),
        .rdy (rdy1), .done (done1), .ab (ab1)
    );

    shift_add_multiplier #(.WIDTH(8), .BPC(4)) u_dut4 (
        .clk (clk), .rst_n (rst_n), .req (req4), .sgn (sgn), .a (a), .b (b),
        .rdy (rdy4), .done (done4), .ab (ab4)
    );

    typedef struct {
        bit          s;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] ab;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Cycles from the request cycle to the done cycle: CALC steps plus one.
    function automatic int exp_lat(input bit s, input logic [7:0] bv, input int bpc);
        logic [7:0] m;
        int steps;
        m = (s && bv[7]) ? -bv : bv;
        steps = 8 / bpc;
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
        for (int k = 8 / bpc; k >= 1; k--) begin
            if ((m >> (k * bpc)) == 8'd0) steps = k;
        end
`endif
        return steps + 1;
    endfunction

    task automatic do_op(input bit use4, input string nm, input bit s,
                         input logic [7:0] ia, input logic [7:0] ib, input logic [15:0] exp_ab);
        int cyc;
        int lat;
        lat = exp_lat(s, ib, use4 ? 4 : 1);
        cyc = 0;
        while (!(use4 ? rdy4 : rdy1) && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        chk({nm, "_rdy"}, 32'(use4 ? rdy4 : rdy1), 32'd1);
        sgn = s; a = ia; b = ib;
        if (use4) req4 = 1'b1; else req1 = 1'b1;
        @(posedge clk); #1;
        req1 = 1'b0; req4 = 1'b0;
        chk({nm, "_busy"}, 32'(use4 ? rdy4 : rdy1), 32'd0);
        cyc = 1;
        while (!(use4 ? done4 : done1) && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        chk({nm, "_done"}, 32'(use4 ? done4 : done1), 32'd1);
        chk({nm, "_lat"}, 32'(cyc), 32'(lat));
        chk({nm, "_ab"}, 32'(use4 ? ab4 : ab1), 32'(exp_ab));
        @(posedge clk); #1;
        chk({nm, "_idle"}, 32'(use4 ? {done4, rdy4} : {done1, rdy1}), 32'b01);
    endtask

    initial begin
        int cyc;
        int lat;
        int busy_bad;
        int stray_done;

        vecs[0]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[1]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[2]  = '{1'b1, 8'hFD, 8'h05, 16'hFFF1};
        vecs[3]  = '{1'b0, 8'h0C, 8'h0A, 16'h0078};
        vecs[4]  = '{1'b0, 8'h55, 8'h01, 16'h0055};
        vecs[5]  = '{1'b0, 8'h55, 8'h80, 16'h2A80};
        vecs[6]  = '{1'b0, 8'h00, 8'h37, 16'h0000};
        vecs[7]  = '{1'b1, 8'h7F, 8'h80, 16'hC080};
        vecs[8]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        vecs[9]  = '{1'b1, 8'h80, 8'h7F, 16'hC080};
        vecs[10] = '{1'b0, 8'hC8, 8'hC8, 16'h9C40};
        vecs[11] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 32'({rdy1, done1, ab1}), 32'h1_0000 << 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            do_op(1'b0, $sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].ab);
        end

        do_op(1'b1, "bpc4_abcd", 1'b0, 8'hAB, 8'hCD, 16'h88EF);
        do_op(1'b1, "bpc4_ffff", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
        do_op(1'b1, "bpc4_sgn",  1'b1, 8'hFD, 8'h05, 16'hFFF1);

        // Busy protection: req stays high and a changes during CALC.
        lat = exp_lat(1'b0, 8'h0A, 1);
        sgn = 1'b0; a = 8'h0C; b = 8'h0A; req1 = 1'b1;
        @(posedge clk); #1;
        a = 8'h77;
        busy_bad = 0;
        cyc = 1;
        while (!done1 && cyc < 40) begin
            if (rdy1) busy_bad++;
            @(posedge clk); #1; cyc++;
        end
        chk("busy_rdy_low", 32'(busy_bad), 32'd0);
        chk("busy_done1", 32'(done1), 32'd1);
        chk("busy_lat1", 32'(cyc), 32'(lat));
        chk("busy_ab1", 32'(ab1), 32'h0078);
        @(posedge clk); #1;
        chk("busy_idle", 32'({done1, rdy1}), 32'b01);
        chk("busy_ab_hold", 32'(ab1), 32'h0078);
        @(posedge clk); #1;
        req1 = 1'b0;
        chk("busy_reaccept", 32'(rdy1), 32'd0);
        cyc = 1;
        while (!done1 && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        chk("busy_done2", 32'(done1), 32'd1);
        chk("busy_lat2", 32'(cyc), 32'(lat));
        chk("busy_ab2", 32'(ab1), 32'h04A6);
        @(posedge clk); #1;

        // Reset during the fourth CALC cycle aborts with no done.
        sgn = 1'b0; a = 8'hC8; b = 8'hC8; req1 = 1'b1;
        @(posedge clk); #1;
        req1 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("rst_pre_done", 32'(done1), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_ab", 32'(ab1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_rdy", 32'(rdy1), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        stray_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done1) stray_done++;
        end
        chk("rst_no_done", 32'(stray_done), 32'd0);
        do_op(1'b0, "post_rst", 1'b0, 8'hC8, 8'hC8, 16'h9C40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
